spi_master_cmd: RTL and testbench

SPI master that issues single register read/write transactions toward the clockmaster's SPI slave port (MOSI/SCLK/SSEL/MISO), the other end of the link that feeds the internal 8-bit address/data register bus. A local controller requests one transaction at a time with a start/busy/done handshake. The block serialises a fixed 3-byte frame, SPI mode 0, MSB first, and returns the byte read back on MISO. It is used for on-board bring-up and for loopback verification against the 10 MHz register map.

---
 rtl/spi_master_cmd.sv | 142 ++++++++++++++
 tb/tb_spi_master_cmd.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_cmd.sv
// SPI mode-0 master issuing one 3-byte register read/write frame per request.
// Every SPI pin and handshake output is a flop; the FSM computes next-cycle values.
module spi_master_cmd #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic       i_clk_10,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_data,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic       o_SCLK,
    output logic       o_MOSI,
    output logic       o_SSEL,
    input  logic       i_MISO
);
    localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LD = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [4:0]  bit_cnt, bit_cnt_nxt;
    logic [23:0] tx_sr, tx_sr_nxt;
    logic [7:0]  rx_sr, rx_sr_nxt;
    logic        sclk_nxt, ssel_nxt, mosi_nxt, busy_nxt, done_nxt;
    logic [7:0]  rdata_nxt;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        tx_sr_nxt   = tx_sr;
        rx_sr_nxt   = rx_sr;
        sclk_nxt    = o_SCLK;
        ssel_nxt    = o_SSEL;
        mosi_nxt    = o_MOSI;
        busy_nxt    = o_busy;
        done_nxt    = 1'b0;
        rdata_nxt   = o_rdata;
        case (state)
            IDLE, DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
                // DONE accepts too, so a held i_start chains frames back-to-back
                if (i_start) begin
                    tx_sr_nxt   = {i_rw, 7'h00, i_addr, (i_rw ? i_data : 8'h00)};
                    state_nxt   = SETUP;
                    cnt_nxt     = DIV_LD;
                    bit_cnt_nxt = 5'd0;
                    ssel_nxt    = 1'b0;
                    mosi_nxt    = i_rw;
                    busy_nxt    = 1'b1;
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    state_nxt = SHIFT;
                    sclk_nxt  = 1'b1;
                    cnt_nxt   = DIV_LD;
                    rx_sr_nxt = {rx_sr[6:0], i_MISO};
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            SHIFT: begin
                if (cnt != 8'd0) begin
                    cnt_nxt = cnt - 8'd1;
                end else if (o_SCLK) begin
                    sclk_nxt = 1'b0;
                    cnt_nxt  = DIV_LD;
                    if (bit_cnt != 5'd23) begin
                        tx_sr_nxt = {tx_sr[22:0], 1'b0};
                        mosi_nxt  = tx_sr[22];
                    end
                end else if (bit_cnt == 5'd23) begin
                    state_nxt = HOLD;
                    cnt_nxt   = DIV_LD;
                end else begin
                    // rising edge: MISO is sampled on the same edge SCLK goes high
                    sclk_nxt    = 1'b1;
                    cnt_nxt     = DIV_LD;
                    bit_cnt_nxt = bit_cnt + 5'd1;
                    rx_sr_nxt   = {rx_sr[6:0], i_MISO};
                end
            end
            HOLD: begin
                if (cnt == 8'd0) begin
                    state_nxt = GAP;
                    ssel_nxt  = 1'b1;
                    cnt_nxt   = GAP_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            GAP: begin
                if (cnt == 8'd0) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    rdata_nxt = rx_sr;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_10) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            bit_cnt <= 5'd0;
            tx_sr   <= 24'd0;
            rx_sr   <= 8'd0;
            o_SCLK  <= 1'b0;
            o_SSEL  <= 1'b1;
            o_MOSI  <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_rdata <= 8'h00;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            tx_sr   <= tx_sr_nxt;
            rx_sr   <= rx_sr_nxt;
            o_SCLK  <= sclk_nxt;
            o_SSEL  <= ssel_nxt;
            o_MOSI  <= mosi_nxt;
            o_busy  <= busy_nxt;
            o_done  <= done_nxt;
            o_rdata <= rdata_nxt;
        end
    end
endmodule

// File: tb/tb_spi_master_cmd.sv
// Scoreboard bench: instance 0 at default timing, instance 1 at CLK_DIV=1/GAP_CYCLES=1.
module tb_spi_master_cmd;
    typedef struct {
        logic [23:0] frame;
        logic [7:0]  rdata;
        int          lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start[2], rw[2], miso[2];
    logic [7:0] addr[2], data[2];
    logic       busy[2], done[2], sclk[2], mosi[2], ssel[2];
    logic [7:0] rdata[2];
    logic [23:0] pat[2];
    int         last_run[2];
    int         cyc = 0;
    int         n_chk = 0, n_fail = 0;
    exp_t       q0[$], q1[$];

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_ch
        localparam int CD  = (g == 0) ? 2 : 1;
        localparam int GAP = (g == 0) ? 4 : 1;

        spi_master_cmd #(.CLK_DIV(CD), .GAP_CYCLES(GAP)) dut (
            .i_clk_10(clk), .i_rst(rst), .i_start(start[g]), .i_rw(rw[g]),
            .i_addr(addr[g]), .i_data(data[g]), .o_busy(busy[g]), .o_done(done[g]),
            .o_rdata(rdata[g]), .o_SCLK(sclk[g]), .o_MOSI(mosi[g]), .o_SSEL(ssel[g]),
            .i_MISO(miso[g])
        );

        logic [23:0] cap = 24'd0, sh = 24'd0;
        int acc_cyc = 0, rises = 0, hi = 0, bcnt = 0, run = 0;
        logic sclk_p = 1'b0, ssel_p = 1'b1;

        // monitor + mode-0 slave, both sampling away from the rising clock edge
        always @(negedge clk) begin
            exp_t e;
            if (done[g]) begin
                if ((g == 0 ? q0.size() : q1.size()) == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_done ch%0d: got o_done=1, required no pulse (cycle %0d)", g, cyc);
                end else begin
                    if (g == 0) e = q0.pop_front(); else e = q1.pop_front();
                    check($sformatf("frame_ch%0d", g), 32'(cap), 32'(e.frame));
                    check($sformatf("rises_ch%0d", g), rises, 24);
                    check($sformatf("sclk_hi_ch%0d", g), hi, 24 * CD);
                    check($sformatf("latency_ch%0d", g), cyc - acc_cyc, e.lat);
                    check($sformatf("busy_cycles_ch%0d", g), bcnt, e.lat - 1);
                    check($sformatf("rdata_ch%0d", g), 32'(rdata[g]), 32'(e.rdata));
                end
            end
            if (start[g] && !busy[g] && !rst) begin
                acc_cyc = cyc; cap = 24'd0; rises = 0; hi = 0; bcnt = 0;
            end else begin
                if (sclk[g] && !sclk_p) begin
                    cap = {cap[22:0], mosi[g]};
                    rises++;
                end
                if (sclk[g]) hi++;
                if (busy[g]) bcnt++;
            end
            if (!ssel[g] && ssel_p) begin
                sh = pat[g];
                miso[g] = sh[23];
            end else if (!ssel[g] && !sclk[g] && sclk_p) begin
                sh = {sh[22:0], 1'b0};
                miso[g] = sh[23];
            end
            if (ssel[g]) run++;
            else begin
                if (run > 0) last_run[g] = run;
                run = 0;
            end
            sclk_p = sclk[g];
            ssel_p = ssel[g];
        end
    end

    task automatic issue(input int g, input logic r, input logic [7:0] a, input logic [7:0] d,
                         input logic [23:0] p, input bit push);
        exp_t e;
        pat[g] = p; rw[g] = r; addr[g] = a; data[g] = d; start[g] = 1'b1;
        e.frame = {r, 7'h00, a, (r ? d : 8'h00)};
        e.rdata = p[7:0];
        e.lat   = (g == 0) ? 105 : 52;
        if (push) begin
            if (g == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(posedge clk); #1;
        start[g] = 1'b0; rw[g] = ~r; addr[g] = 8'hEE; data[g] = 8'h11;
    endtask

    task automatic wait_done(input int g, output int t);
        t = -1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (done[g]) begin t = cyc; break; end
        end
        if (t < 0) begin
            n_chk++; n_fail++;
            $display("FAIL timeout_ch%0d: o_done not seen within 400 cycles", g);
        end
    endtask

    initial begin
        int t1, t2;
        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            start[g] = 0; rw[g] = 0; addr[g] = 0; data[g] = 0; miso[g] = 0;
            pat[g] = 24'd0; last_run[g] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check("rst_ssel", ssel[g], 1'b1);
            check("rst_sclk", sclk[g], 1'b0);
            check("rst_mosi", mosi[g], 1'b0);
            check("rst_busy", busy[g], 1'b0);
            check("rst_done", done[g], 1'b0);
            check("rst_rdata", rdata[g], 8'h00);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // write at default timing; slave returns 0x96 in byte2
        issue(0, 1'b1, 8'h12, 8'h5A, 24'hA55A96, 1'b1);
        wait_done(0, t1);
        repeat (5) @(posedge clk);
        #1;

        // read; slave drives 0xC3 during byte2
        issue(0, 1'b0, 8'h07, 8'h99, 24'h0000C3, 1'b1);
        wait_done(0, t1);
        repeat (10) @(posedge clk);
        #1;
        check("rdata_held", rdata[0], 8'hC3);

        // start while busy must be ignored
        issue(0, 1'b1, 8'h12, 8'h33, 24'h123456, 1'b1);
        repeat (29) @(posedge clk);
        #1;
        start[0] = 1'b1; addr[0] = 8'hFF; rw[0] = 1'b0;
        @(posedge clk); #1;
        start[0] = 1'b0;
        wait_done(0, t1);
        repeat (20) @(posedge clk);
        #1;

        // reset at cycle 20 of a frame
        issue(0, 1'b1, 8'h56, 8'h78, 24'hFFFFFF, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_ssel", ssel[0], 1'b1);
        check("midrst_sclk", sclk[0], 1'b0);
        check("midrst_mosi", mosi[0], 1'b0);
        check("midrst_busy", busy[0], 1'b0);
        check("midrst_rdata", rdata[0], 8'h00);
        check("midrst_done", done[0], 1'b0);
        rst = 1'b0;
        repeat (120) @(posedge clk);
        #1;
        issue(0, 1'b1, 8'h34, 8'hA1, 24'h00005E, 1'b1);
        wait_done(0, t1);
        repeat (5) @(posedge clk);
        #1;

        // back-to-back with i_start held high
        pat[0] = 24'h0000E7; rw[0] = 1'b1; addr[0] = 8'h21; data[0] = 8'h43; start[0] = 1'b1;
        q0.push_back('{frame: 24'h802143, rdata: 8'hE7, lat: 105});
        @(posedge clk); #1;
        addr[0] = 8'h22; data[0] = 8'h44;
        q0.push_back('{frame: 24'h802244, rdata: 8'hE7, lat: 105});
        wait_done(0, t1);
        @(posedge clk); #1;
        start[0] = 1'b0;
        wait_done(0, t2);
        check("b2b_done_spacing", t2 - t1, 105);
        check("b2b_ssel_high", last_run[0], 5);

        // fastest timing on instance 1
        issue(1, 1'b1, 8'h12, 8'h5A, 24'h00003C, 1'b1);
        wait_done(1, t1);
        repeat (10) @(posedge clk);
        #1;

        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
